// File: rtl/mcast_fork_ctrl.sv
// Per-input-port fork controller: latches a packet's destination bitmap, collects and
// holds every output grant, then forwards flits in lock-step to all destinations.
module mcast_fork_ctrl #(
  parameter int PORTS   = 5,
  parameter int TIMEOUT = 16,
  parameter int BACKOFF = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  input  logic             in_head,
  input  logic             in_tail,
  input  logic [PORTS-1:0] in_dst,
  output logic             in_ack,
  output logic [PORTS-1:0] out_req,
  input  logic [PORTS-1:0] out_grt,
  input  logic [PORTS-1:0] out_rdy,
  output logic [PORTS-1:0] out_send,
  output logic             mcast,
  output logic             busy,
  output logic             err,
  output logic [1:0]       o_dbg_state
);

  localparam int TMAX = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_XFER    = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PORTS-1:0] r_dst, w_dst_nxt;
  logic [PORTS-1:0] r_got, w_got_nxt;
  logic [TW-1:0]    r_tmr, w_tmr_nxt;
  logic             r_err, w_err_nxt;
  logic [PORTS-1:0] w_req, w_send;
  logic             w_ack;
  logic             w_full, w_fire;

  // A branch counts as granted if it was latched earlier or is granted this cycle.
  assign w_full = (((r_got | out_grt) & r_dst) == r_dst);
  assign w_fire = in_valid & (&(out_rdy | ~r_dst));

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state <= S_IDLE;
      r_dst   <= '0;
      r_got   <= '0;
      r_tmr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dst   <= w_dst_nxt;
      r_got   <= w_got_nxt;
      r_tmr   <= w_tmr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dst_nxt   = r_dst;
    w_got_nxt   = r_got;
    w_tmr_nxt   = r_tmr;
    w_err_nxt   = r_err;
    w_req       = '0;
    w_send      = '0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_head) begin
          if (in_dst == '0) begin
            // Destination-less head is dropped so it cannot block the input buffer.
            w_ack     = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_dst_nxt   = in_dst;
            w_got_nxt   = '0;
            w_tmr_nxt   = '0;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_req = r_dst;
        if (w_full) begin
          w_got_nxt   = r_got | (out_grt & r_dst);
          w_state_nxt = S_XFER;
        end else if (r_tmr == TW'(TIMEOUT - 1)) begin
          w_got_nxt   = '0;
          w_tmr_nxt   = '0;
          w_state_nxt = S_BACKOFF;
        end else begin
          w_got_nxt = r_got | (out_grt & r_dst);
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_XFER: begin
        w_req = r_dst;
        if (w_fire) begin
          w_ack  = 1'b1;
          w_send = r_dst;
          if (in_tail) w_state_nxt = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (r_tmr == TW'(BACKOFF - 1)) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_REQ;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ack      = w_ack & ~rst_;
  assign out_req     = w_req & {PORTS{~rst_}};
  assign out_send    = w_send & {PORTS{~rst_}};
  assign mcast       = (r_state != S_IDLE) && ($countones(r_dst) > 1);
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mcast_fork_ctrl.sv
// Directed bench for mcast_fork_ctrl: inputs change 2ns after the rising edge,
// outputs are compared 1ns later, well clear of either clock edge.
module tb_mcast_fork_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_BOFF = 2'd3;

  logic       clk = 1'b0;
  logic       rst_;
  logic       in_valid, in_head, in_tail;
  logic [4:0] in_dst, out_grt, out_rdy;
  logic       in_ack;
  logic [4:0] out_req, out_send;
  logic       mcast, busy, err;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mcast_fork_ctrl #(.PORTS(5), .TIMEOUT(16), .BACKOFF(4)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .in_valid   (in_valid),
    .in_head    (in_head),
    .in_tail    (in_tail),
    .in_dst     (in_dst),
    .in_ack     (in_ack),
    .out_req    (out_req),
    .out_grt    (out_grt),
    .out_rdy    (out_rdy),
    .out_send   (out_send),
    .mcast      (mcast),
    .busy       (busy),
    .err        (err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [4:0] dst, input logic [4:0] grt, input logic [4:0] rdy);
    in_valid = v;
    in_head  = h;
    in_tail  = t;
    in_dst   = dst;
    out_grt  = grt;
    out_rdy  = rdy;
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic [4:0] req, input logic [4:0] send,
                             input logic ack, input logic [1:0] st);
    chk({tag, ".req"},   32'(out_req),   32'(req));
    chk({tag, ".send"},  32'(out_send),  32'(send));
    chk({tag, ".ack"},   32'(in_ack),    32'(ack));
    chk({tag, ".state"}, 32'(dbg_state), 32'(st));
  endtask

  initial begin : stim
    logic [4:0] t2_grt [4];
    t2_grt[0] = 5'b00001;
    t2_grt[1] = 5'b00001;
    t2_grt[2] = 5'b00011;
    t2_grt[3] = 5'b10011;

    rst_ = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'b0, 5'b0, 5'b0);
    repeat (2) @(posedge clk);
    #2;
    expect_outs("reset", 5'b0, 5'b0, 1'b0, ST_IDLE);
    chk("reset.mcast", 32'(mcast), 32'd0);
    chk("reset.busy",  32'(busy),  32'd0);
    chk("reset.err",   32'(err),   32'd0);
    rst_ = 1'b0;

    // 1: unicast, three flits
    tick(); drive(1, 1, 0, 5'b00100, 5'b00000, 5'b11111);
    expect_outs("t1.idle", 5'b0, 5'b0, 0, ST_IDLE);
    tick(); drive(1, 1, 0, 5'b00100, 5'b00100, 5'b11111);
    expect_outs("t1.req", 5'b00100, 5'b0, 0, ST_REQ);
    chk("t1.req.mcast", 32'(mcast), 32'd0);
    tick(); drive(1, 1, 0, 5'b00100, 5'b00100, 5'b11111);
    expect_outs("t1.head", 5'b00100, 5'b00100, 1, ST_XFER);
    chk("t1.mcast", 32'(mcast), 32'd0);
    tick(); drive(1, 0, 0, 5'b00000, 5'b00100, 5'b11111);
    expect_outs("t1.body", 5'b00100, 5'b00100, 1, ST_XFER);
    tick(); drive(1, 0, 1, 5'b00000, 5'b00100, 5'b11111);
    expect_outs("t1.tail", 5'b00100, 5'b00100, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t1.done", 5'b0, 5'b0, 0, ST_IDLE);
    chk("t1.done.busy", 32'(busy), 32'd0);

    // 2: multicast, grants trickle in over cycles 1..4
    tick(); drive(1, 1, 0, 5'b10011, 5'b00000, 5'b11111);
    expect_outs("t2.idle", 5'b0, 5'b0, 0, ST_IDLE);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1, 1, 0, 5'b10011, t2_grt[i], 5'b11111);
      expect_outs($sformatf("t2.req%0d", i + 1), 5'b10011, 5'b0, 0, ST_REQ);
      chk($sformatf("t2.req%0d.mcast", i + 1), 32'(mcast), 32'd1);
    end
    tick(); drive(1, 1, 0, 5'b10011, 5'b10011, 5'b11111);
    expect_outs("t2.head", 5'b10011, 5'b10011, 1, ST_XFER);
    chk("t2.head.mcast", 32'(mcast), 32'd1);
    tick(); drive(1, 0, 1, 5'b00000, 5'b10011, 5'b11111);
    expect_outs("t2.tail", 5'b10011, 5'b10011, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t2.done", 5'b0, 5'b0, 0, ST_IDLE);
    chk("t2.done.mcast", 32'(mcast), 32'd0);

    // 3: credit stall on port 1 mid-packet
    tick(); drive(1, 1, 0, 5'b00011, 5'b00000, 5'b11111);
    tick(); drive(1, 1, 0, 5'b00011, 5'b00011, 5'b11111);
    expect_outs("t3.req", 5'b00011, 5'b0, 0, ST_REQ);
    tick(); drive(1, 1, 0, 5'b00011, 5'b00011, 5'b11111);
    expect_outs("t3.head", 5'b00011, 5'b00011, 1, ST_XFER);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1, 0, 0, 5'b00000, 5'b00011, 5'b11101);
      expect_outs($sformatf("t3.stall%0d", i), 5'b00011, 5'b0, 0, ST_XFER);
    end
    tick(); drive(1, 0, 0, 5'b00000, 5'b00011, 5'b11111);
    expect_outs("t3.body", 5'b00011, 5'b00011, 1, ST_XFER);
    tick(); drive(1, 0, 1, 5'b00000, 5'b00011, 5'b11111);
    expect_outs("t3.tail", 5'b00011, 5'b00011, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t3.done", 5'b0, 5'b0, 0, ST_IDLE);

    // 4: partial grant forever -> timeout, backoff, retry with cleared grants
    tick(); drive(1, 1, 1, 5'b00110, 5'b00000, 5'b11111);
    for (int i = 0; i < 16; i++) begin
      tick(); drive(1, 1, 1, 5'b00110, 5'b00010, 5'b11111);
      expect_outs($sformatf("t4.req%0d", i), 5'b00110, 5'b0, 0, ST_REQ);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1, 1, 1, 5'b00110, 5'b00000, 5'b11111);
      expect_outs($sformatf("t4.boff%0d", i), 5'b0, 5'b0, 0, ST_BOFF);
      chk($sformatf("t4.boff%0d.busy", i), 32'(busy), 32'd1);
    end
    tick(); drive(1, 1, 1, 5'b00110, 5'b00100, 5'b11111);
    expect_outs("t4.retry", 5'b00110, 5'b0, 0, ST_REQ);
    tick(); drive(1, 1, 1, 5'b00110, 5'b00110, 5'b11111);
    expect_outs("t4.got_clr", 5'b00110, 5'b0, 0, ST_REQ);
    tick(); drive(1, 1, 1, 5'b00110, 5'b00110, 5'b11111);
    expect_outs("t4.send", 5'b00110, 5'b00110, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t4.done", 5'b0, 5'b0, 0, ST_IDLE);

    // 5a: single-flit packet
    tick(); drive(1, 1, 1, 5'b01000, 5'b00000, 5'b11111);
    tick(); drive(1, 1, 1, 5'b01000, 5'b01000, 5'b11111);
    expect_outs("t5.req", 5'b01000, 5'b0, 0, ST_REQ);
    tick(); drive(1, 1, 1, 5'b01000, 5'b01000, 5'b11111);
    expect_outs("t5.send", 5'b01000, 5'b01000, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t5.done", 5'b0, 5'b0, 0, ST_IDLE);
    chk("t5.err_before", 32'(err), 32'd0);

    // 5b: empty destination bitmap is dropped
    drive(1, 1, 1, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t5.drop", 5'b0, 5'b0, 1, ST_IDLE);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t5.after", 5'b0, 5'b0, 0, ST_IDLE);
    chk("t5.err", 32'(err), 32'd1);

    // 6: asynchronous reset in the middle of a stalled transfer
    tick(); drive(1, 1, 0, 5'b00001, 5'b00000, 5'b11111);
    tick(); drive(1, 1, 0, 5'b00001, 5'b00001, 5'b11111);
    tick(); drive(1, 1, 0, 5'b00001, 5'b00001, 5'b00000);
    expect_outs("t6.stall", 5'b00001, 5'b0, 0, ST_XFER);
    drive(1, 1, 0, 5'b00001, 5'b00001, 5'b11111);
    rst_ = 1'b1;
    #1;
    expect_outs("t6.rst", 5'b0, 5'b0, 0, ST_IDLE);
    chk("t6.rst.busy",  32'(busy),  32'd0);
    chk("t6.rst.mcast", 32'(mcast), 32'd0);
    chk("t6.rst.err",   32'(err),   32'd0);
    tick();
    expect_outs("t6.rst_hold", 5'b0, 5'b0, 0, ST_IDLE);
    rst_ = 1'b0;
    drive(1, 1, 1, 5'b00001, 5'b00000, 5'b11111);
    expect_outs("t6.idle", 5'b0, 5'b0, 0, ST_IDLE);
    tick(); drive(1, 1, 1, 5'b00001, 5'b00001, 5'b11111);
    expect_outs("t6.req", 5'b00001, 5'b0, 0, ST_REQ);
    tick(); drive(1, 1, 1, 5'b00001, 5'b00001, 5'b11111);
    expect_outs("t6.send", 5'b00001, 5'b00001, 1, ST_XFER);
    tick(); drive(0, 0, 0, 5'b00000, 5'b00000, 5'b11111);
    expect_outs("t6.done", 5'b0, 5'b0, 0, ST_IDLE);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
